// File: rtl/sigma_delta_adc_scheduler_pkg.sv
// sigma_delta_pkg: shared state encoding and width helper for the ADC bank scheduler
package sigma_delta_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_SETTLE, ST_RUN} sched_state_t;

    // Bits needed to index n items; never returns 0 so single-item widths stay legal
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sigma_delta_adc_scheduler_arbiter.sv
// sigma_delta_rr_arbiter: combinational round-robin pick of the first request at or above ptr
//   req_i       : request vector
//   ptr_i       : search start index
//   gnt_valid_o : some request is set
//   gnt_idx_o   : index of the winning request
module sigma_delta_rr_arbiter import sigma_delta_pkg::*; #(
    parameter  int N = 4,
    localparam int W = ch_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         gnt_valid_o,
    output logic [W-1:0] gnt_idx_o
);

    // Scan from the farthest offset down so the nearest request above ptr wins last
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sigma_delta_adc_scheduler.sv
// sigma_delta_adc_scheduler: sequences an ADC bank through reset/settle and merges samples onto one stream
//   clk, rst             : clock, async active-high reset
//   enable               : run level; low aborts to idle
//   adc_rst              : per-channel ADC reset
//   adc_output/adc_valid : packed channel samples and strobes
//   m_data/m_chan/m_valid/m_ready : tagged valid/ready output
//   overrun/overrun_clr  : sticky lost-sample flags and clear
//   running              : high in run state
module sigma_delta_adc_scheduler import sigma_delta_pkg::*; #(
    parameter  int NUM_CHANNELS    = 4,
    parameter  int ADC_BITLEN      = 24,
    parameter  int RST_CYCLES      = 8,
    parameter  int DISCARD_SAMPLES = 2,
    localparam int CH_W            = ch_w(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    output logic [NUM_CHANNELS-1:0]            adc_rst,
    input  logic [NUM_CHANNELS*ADC_BITLEN-1:0] adc_output,
    input  logic [NUM_CHANNELS-1:0]            adc_valid,
    output logic [ADC_BITLEN-1:0]              m_data,
    output logic [CH_W-1:0]                    m_chan,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [NUM_CHANNELS-1:0]            overrun,
    input  logic                               overrun_clr,
    output logic                               running
);

    localparam int RW = ch_w(RST_CYCLES + 1);
    localparam int DW = ch_w(DISCARD_SAMPLES + 1);

    sched_state_t            state_q;
    logic [RW-1:0]           rcnt_q;
    logic [DW-1:0]           dcnt_q [NUM_CHANNELS];
    logic [ADC_BITLEN-1:0]   hold_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pend_q, pend_d, ovr_d, cap, dinc, gnt_oh;
    logic [CH_W-1:0]         rr_q, gnt_idx;
    logic                    gnt_valid, load, settled;

    sigma_delta_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
        .req_i      (pend_q),
        .ptr_i      (rr_q),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );

    assign load   = !m_valid || m_ready;
    assign gnt_oh = (load && gnt_valid) ? (NUM_CHANNELS'(1) << gnt_idx) : '0;
    assign cap    = (state_q == ST_RUN && enable) ? adc_valid : '0;
    // A granted channel frees its slot this cycle, so a same-cycle strobe refills it without overrun
    assign pend_d = (pend_q & ~gnt_oh) | cap;
    assign ovr_d  = (overrun & ~{NUM_CHANNELS{overrun_clr}}) | (cap & pend_q & ~gnt_oh);

    // Settled looks at next-count so the run state starts right after the last discarded strobe
    always_comb begin
        settled = 1'b1;
        dinc    = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            dinc[c] = adc_valid[c] && (dcnt_q[c] != DW'(DISCARD_SAMPLES));
            if (dcnt_q[c] + DW'(dinc[c]) != DW'(DISCARD_SAMPLES)) settled = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            adc_rst <= '1;
            pend_q  <= '0;
            rr_q    <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            overrun <= '0;
            running <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                dcnt_q[c] <= '0;
                hold_q[c] <= '0;
            end
        end else begin
            overrun <= ovr_d;
            if (!enable) begin
                state_q <= ST_IDLE;
                adc_rst <= '1;
                pend_q  <= '0;
                m_valid <= 1'b0;
                running <= 1'b0;
            end else begin
                pend_q <= pend_d;
                for (int c = 0; c < NUM_CHANNELS; c++)
                    if (cap[c]) hold_q[c] <= adc_output[c*ADC_BITLEN +: ADC_BITLEN];
                if (load) begin
                    m_valid <= gnt_valid;
                    if (gnt_valid) begin
                        m_data <= hold_q[gnt_idx];
                        m_chan <= gnt_idx;
                        rr_q   <= (gnt_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : gnt_idx + CH_W'(1);
                    end
                end
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_RESET;
                        rcnt_q  <= RW'(RST_CYCLES);
                        for (int c = 0; c < NUM_CHANNELS; c++) dcnt_q[c] <= '0;
                    end
                    ST_RESET: begin
                        rcnt_q <= rcnt_q - RW'(1);
                        if (rcnt_q == RW'(1)) begin
                            adc_rst <= '0;
                            state_q <= (DISCARD_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
                            running <= (DISCARD_SAMPLES == 0);
                        end
                    end
                    ST_SETTLE: begin
                        for (int c = 0; c < NUM_CHANNELS; c++)
                            if (dinc[c]) dcnt_q[c] <= dcnt_q[c] + DW'(1);
                        if (settled) begin
                            state_q <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_adc_scheduler.sv
// tb_sigma_delta_adc_scheduler: directed self-checking bench for the ADC bank scheduler
module tb_sigma_delta_adc_scheduler;
    import sigma_delta_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  adc_rst;
    logic [95:0] adc_output = '0;
    logic [3:0]  adc_valid = '0;
    logic [23:0] m_data;
    logic [1:0]  m_chan;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  overrun;
    logic        overrun_clr = 1'b0;
    logic        running;

    int total = 0;
    int bad = 0;
    logic [31:0] got[$];
    logic [31:0] expq[$];

    sigma_delta_adc_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .adc_rst    (adc_rst),
        .adc_output (adc_output),
        .adc_valid  (adc_valid),
        .m_data     (m_data),
        .m_chan     (m_chan),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .running    (running)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (m_valid && m_ready) got.push_back({6'd0, m_chan, m_data});

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [3:0] m, input logic [95:0] d);
        adc_output = d;
        adc_valid = m;
        step(1);
        adc_valid = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        pv, pr;
        logic [23:0] pd;
        logic [1:0]  pc;

        // Reset state
        step(2);
        chk("rst_adc_rst", adc_rst, 4'hF);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_chan", m_chan, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_running", running, 0);
        rst = 1'b0;
        step(3);

        // 1: startup sequencing and settle discard
        enable = 1'b1;
        step(1);
        chk("s1_adc_rst_first", adc_rst, 4'hF);
        step(7);
        chk("s1_adc_rst_last", adc_rst, 4'hF);
        step(1);
        chk("s1_adc_rst_drop", adc_rst, 4'h0);
        chk("s1_not_running", running, 0);
        strobe(4'hF, {24'hE3, 24'hE2, 24'hE1, 24'hE0});
        strobe(4'h7, {24'hF3, 24'hF2, 24'hF1, 24'hF0});
        strobe(4'h1, {24'h0, 24'h0, 24'h0, 24'hF9});
        chk("s1_wait_slowest", running, 0);
        strobe(4'h8, {24'hF3, 24'h0, 24'h0, 24'h0});
        chk("s1_running", running, 1);
        step(3);
        chk("s1_no_beat", m_valid, 0);
        chk("s1_no_output", got.size(), 0);

        // 2: simultaneous strobes drain in channel order
        m_ready = 1'b1;
        strobe(4'hF, {24'h40, 24'h30, 24'h20, 24'h10});
        chk("s2_latency", m_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("s2_valid", m_valid, 1);
            chk("s2_chan", m_chan, i);
            chk("s2_data", m_data, (i + 1) * 16);
        end
        step(1);
        chk("s2_drained", m_valid, 0);
        chk("s2_rr_ptr", dut.rr_q, 0);

        // 3: overrun while stalled, newest sample wins
        m_ready = 1'b0;
        strobe(4'h2, {24'h0, 24'h0, 24'h111, 24'h0});
        step(1);
        chk("s3_reg_chan", m_chan, 1);
        strobe(4'h4, {24'h0, 24'hAAA, 24'h0, 24'h0});
        step(3);
        chk("s3_no_ovr_yet", overrun, 0);
        strobe(4'h4, {24'h0, 24'hBBB, 24'h0, 24'h0});
        chk("s3_overrun", overrun, 4'h4);
        step(14);
        chk("s3_hold_valid", m_valid, 1);
        chk("s3_hold_data", m_data, 24'h111);
        got.delete();
        m_ready = 1'b1;
        step(4);
        chk("s3_beats", got.size(), 2);
        if (got.size() == 2) begin
            chk("s3_beat0", got[0], {8'd1, 24'h111});
            chk("s3_beat1", got[1], {8'd2, 24'hBBB});
        end
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chk("s3_ovr_clr", overrun, 0);

        // 4: toggling backpressure, ch1 every third cycle
        got.delete();
        expq.delete();
        for (int i = 0; i < 24; i++) begin
            m_ready = (i % 2 == 0);
            adc_valid = (i % 3 == 0) ? 4'h2 : 4'h0;
            adc_output = {24'h0, 24'h0, 24'h100 + 24'(i), 24'h0};
            if (i % 3 == 0) expq.push_back({8'd1, 24'h100 + 24'(i)});
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pc = m_chan;
            step(1);
            if (pv && !pr) begin
                chk("s4_stable_data", m_data, pd);
                chk("s4_stable_chan", m_chan, pc);
            end
        end
        adc_valid = '0;
        m_ready = 1'b1;
        step(4);
        chk("s4_count", got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++) chk("s4_beat", got[i], expq[i]);
        chk("s4_no_overrun", overrun, 0);

        // 5: abort with a stalled beat, then restart
        m_ready = 1'b0;
        strobe(4'h1, {24'h0, 24'h0, 24'h0, 24'h55});
        step(1);
        chk("s5_valid", m_valid, 1);
        chk("s5_data", m_data, 24'h55);
        enable = 1'b0;
        step(1);
        chk("s5_abort_valid", m_valid, 0);
        chk("s5_abort_adc_rst", adc_rst, 4'hF);
        chk("s5_abort_running", running, 0);
        chk("s5_idle", dut.state_q, ST_IDLE);
        enable = 1'b1;
        step(1);
        chk("s5_adc_rst_first", adc_rst, 4'hF);
        step(7);
        chk("s5_adc_rst_last", adc_rst, 4'hF);
        step(1);
        chk("s5_adc_rst_drop", adc_rst, 4'h0);
        strobe(4'hF, {24'h1, 24'h1, 24'h1, 24'h1});
        chk("s5_settling", running, 0);
        strobe(4'hF, {24'h2, 24'h2, 24'h2, 24'h2});
        chk("s5_running", running, 1);
        step(2);
        chk("s5_beat_lost", m_valid, 0);

        // 6: async reset mid-cycle
        strobe(4'h8, {24'h777, 24'h0, 24'h0, 24'h0});
        strobe(4'h1, {24'h0, 24'h0, 24'h0, 24'h1});
        strobe(4'h1, {24'h0, 24'h0, 24'h0, 24'h2});
        chk("s6_pre_chan", m_chan, 3);
        chk("s6_pre_overrun", overrun, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_m_valid", m_valid, 0);
        chk("s6_m_data", m_data, 0);
        chk("s6_m_chan", m_chan, 0);
        chk("s6_overrun", overrun, 0);
        chk("s6_running", running, 0);
        chk("s6_adc_rst", adc_rst, 4'hF);
        step(1);
        rst = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
